// File: rtl/btb_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl_pkg
//   Shared constants and types for the BTB update controller slice.
//   - XLEN_WIDTH / BTB_ENTRY_NUM : default address width and BTB size.
//   - BTB_UPD_QUEUE_DEPTH        : default depth of the update FIFO.
//   - btb_update_t               : one pending BTB write {addr, target}.
//   - btb_ctrl_state_t           : controller FSM states.
// ---------------------------------------------------------------------------
package btb_update_ctrl_pkg;

  localparam int XLEN_WIDTH          = 32;
  localparam int BTB_ENTRY_NUM       = 64;
  localparam int BTB_UPD_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [XLEN_WIDTH-1:0] addr;
    logic [XLEN_WIDTH-1:0] target;
  } btb_update_t;

  typedef enum logic {
    BTB_CTRL_IDLE  = 1'b0,
    BTB_CTRL_SWEEP = 1'b1
  } btb_ctrl_state_t;

  function automatic btb_update_t make_update(input logic [XLEN_WIDTH-1:0] addr,
                                              input logic [XLEN_WIDTH-1:0] target);
    btb_update_t u;
    u.addr   = addr;
    u.target = target;
    return u;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl_if
//   Bundles the EXE branch reports, the flush request and the BTB-side
//   write/invalidate outputs of btb_update_ctrl.
//   master : EXE / flush source side (drives br*, flush_req).
//   slave  : the controller (drives upd_*, inv_*, busy).
//
// Handshake: a report on brN_* is taken only in a cycle where brN_valid,
// brN_taken and upd_ready are all high. upd_ready is registered and never
// depends on br* in the same cycle. Reports offered while upd_ready is low
// are ignored; EXE stalls and re-presents them. upd_valid/inv_valid have no
// back-pressure: the BTB accepts every cycle they are high.
// ---------------------------------------------------------------------------
interface btb_update_ctrl_if #(
  parameter int XLEN_WIDTH = 32,
  parameter int IDX_W      = 6
);

  logic                  br0_valid;
  logic                  br0_taken;
  logic [XLEN_WIDTH-1:0] br0_addr;
  logic [XLEN_WIDTH-1:0] br0_target;
  logic                  br1_valid;
  logic                  br1_taken;
  logic [XLEN_WIDTH-1:0] br1_addr;
  logic [XLEN_WIDTH-1:0] br1_target;
  logic                  flush_req;

  logic                  upd_ready;
  logic                  upd_valid;
  logic [XLEN_WIDTH-1:0] upd_addr;
  logic [XLEN_WIDTH-1:0] upd_target;
  logic                  inv_valid;
  logic [IDX_W-1:0]      inv_index;
  logic                  busy;

  modport master (
    output br0_valid, br0_taken, br0_addr, br0_target,
    output br1_valid, br1_taken, br1_addr, br1_target,
    output flush_req,
    input  upd_ready, upd_valid, upd_addr, upd_target,
    input  inv_valid, inv_index, busy
  );

  modport slave (
    input  br0_valid, br0_taken, br0_addr, br0_target,
    input  br1_valid, br1_taken, br1_addr, br1_target,
    input  flush_req,
    output upd_ready, upd_valid, upd_addr, upd_target,
    output inv_valid, inv_index, busy
  );

endinterface

// File: rtl/btb_update_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// btb_upd_fifo
//   2-write / 1-read FIFO of btb_update_t. When both write ports fire,
//   wr0 lands first (older) and wr1 in the next slot.
//   Ports:
//     clk, reset_n        : clock, async active-low reset
//     clear               : drop all contents (pointers and count to 0)
//     wr0_en/wr0_data     : first write port
//     wr1_en/wr1_data     : second write port
//     rd_en               : pop the head (only when count != 0)
//     rd_data             : current head entry
//     count               : occupancy, log2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     wr0_en,
  input  btb_update_t              wr0_data,
  input  logic                     wr1_en,
  input  btb_update_t              wr1_data,
  input  logic                     rd_en,
  output btb_update_t              rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  btb_update_t     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr1_ptr;
  logic [PW:0]     count_q;
  logic [1:0]      n_wr;

  always_comb begin
    n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
    wr1_ptr = wr0_en ? (wr_ptr + PW'(1)) : wr_ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally modulo DEPTH (power of two).
      wr_ptr  <= wr_ptr + PW'(n_wr);
      rd_ptr  <= rd_ptr + PW'(rd_en);
      count_q <= count_q + (PW+1)'(n_wr) - (PW+1)'(rd_en);
    end
  end

  // Storage carries no reset; the controller gates the head off the bus
  // whenever it is not being popped.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (wr0_en) mem[wr_ptr]  <= wr0_data;
      if (wr1_en) mem[wr1_ptr] <= wr1_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rd_en && (count_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    clear || ((int'(count_q) + int'(n_wr) - int'(rd_en)) <= DEPTH));

endmodule

// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
//   Serialises all writes into the branch target buffer. Taken branch
//   reports from two EXE units are queued in btb_upd_fifo and drained at one
//   BTB write per cycle. A flush request clears the queue and sweeps an
//   invalidate over every BTB index.
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     bus          : btb_update_ctrl_if slave (br0/br1 reports, flush_req,
//                    upd_* write port, inv_* invalidate port, busy)
//     dbg_state    : current FSM state, for observation only
// ---------------------------------------------------------------------------
module btb_update_ctrl #(
  parameter int BTB_ENTRY_NUM = btb_update_ctrl_pkg::BTB_ENTRY_NUM,
  parameter int QUEUE_DEPTH   = btb_update_ctrl_pkg::BTB_UPD_QUEUE_DEPTH,
  parameter int XLEN_WIDTH    = btb_update_ctrl_pkg::XLEN_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  btb_update_ctrl_if.slave                    bus,
  output btb_update_ctrl_pkg::btb_ctrl_state_t dbg_state
);

  import btb_update_ctrl_pkg::*;

  localparam int IDX_W = $clog2(BTB_ENTRY_NUM);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  btb_ctrl_state_t  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  btb_update_t      head;
  btb_update_t      wr0_data, wr1_data;

  logic take0, take1, dup, enq0, enq1, deq, fifo_clear;

  // ---------------------------------------------------------------------
  // Enqueue / dequeue decisions
  // ---------------------------------------------------------------------
  always_comb begin
    // ready_q is only ever high in IDLE; a flush in the same cycle drops
    // any reports.
    take0      = bus.br0_valid && bus.br0_taken && ready_q && !bus.flush_req;
    take1      = bus.br1_valid && bus.br1_taken && ready_q && !bus.flush_req;
    // Same PC from both units: the younger (br1) report supersedes br0.
    dup        = take0 && take1 && (bus.br0_addr == bus.br1_addr);
    enq0       = take0 && !dup;
    enq1       = take1;
    // A flush discards the queue, so the head is not written that cycle.
    deq        = (state_q == BTB_CTRL_IDLE) && (count != '0) && !bus.flush_req;
    fifo_clear = bus.flush_req;
    wr0_data   = make_update(bus.br0_addr, bus.br0_target);
    wr1_data   = make_update(bus.br1_addr, bus.br1_target);
  end

  btb_upd_fifo #(
    .DEPTH    (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (fifo_clear),
    .wr0_en   (enq0),
    .wr0_data (wr0_data),
    .wr1_en   (enq1),
    .wr1_data (wr1_data),
    .rd_en    (deq),
    .rd_data  (head),
    .count    (count)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BTB_CTRL_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      BTB_CTRL_IDLE: begin
        if (bus.flush_req) begin
          state_d = BTB_CTRL_SWEEP;
          idx_d   = '0;
        end
      end
      BTB_CTRL_SWEEP: begin
        if (bus.flush_req) begin
          idx_d = '0;
        end else if (idx_q == IDX_W'(BTB_ENTRY_NUM - 1)) begin
          state_d = BTB_CTRL_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = BTB_CTRL_IDLE;
        idx_d   = '0;
      end
    endcase

    // Post-edge occupancy; ready is registered from it so EXE sees a
    // flop-driven stall signal.
    if (fifo_clear) begin
      count_d = '0;
    end else begin
      count_d = count + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq);
    end
    ready_d = (state_d == BTB_CTRL_IDLE) &&
              ((CNT_W'(QUEUE_DEPTH) - count_d) >= CNT_W'(2));
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.upd_ready  = ready_q;
    bus.upd_valid  = deq;
    bus.upd_addr   = deq ? head.addr : '0;
    bus.upd_target = deq ? head.target : '0;
    bus.inv_valid  = (state_q == BTB_CTRL_SWEEP);
    bus.inv_index  = (state_q == BTB_CTRL_SWEEP) ? idx_q : '0;
    bus.busy       = (count != '0) || (state_q == BTB_CTRL_SWEEP);
    dbg_state      = state_q;
  end

  // Stalled reports must never slip into the queue.
  a_no_enq_when_stalled: assert property (@(posedge clk) disable iff (!reset_n)
    (enq0 || enq1) |-> ready_q);

  // The write port and the invalidate sweep are mutually exclusive.
  a_no_write_in_sweep: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.upd_valid && bus.inv_valid));

endmodule

// File: tb/tb_btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btb_update_ctrl
//   Directed bench for btb_update_ctrl (64 entries, depth-4 queue, 32-bit).
//   Driver tasks push expected BTB writes into exp_q; a negedge monitor pops
//   and compares on every upd_valid. Sweep, ready and busy timing are
//   checked directly against hand-computed cycle positions.
// ---------------------------------------------------------------------------
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  localparam int XW = 32;
  localparam int N  = 64;
  localparam int QD = 4;
  localparam int IW = 6;

  logic            clk;
  logic            reset_n;
  btb_ctrl_state_t dbg_state;

  btb_update_ctrl_if #(.XLEN_WIDTH(XW), .IDX_W(IW)) bus ();

  btb_update_ctrl #(
    .BTB_ENTRY_NUM (N),
    .QUEUE_DEPTH   (QD),
    .XLEN_WIDTH    (XW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int              tests = 0;
  int              fails = 0;
  logic [2*XW-1:0] exp_q[$];
  logic            rdy_seen;
  logic            wv_seen;
  logic [IW-1:0]   idx_seen;

  // -------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // -------------------------------------------------------------------
  // Scoreboard monitor
  // -------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset_n && bus.upd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h target 0x%0h, expected no write",
                 bus.upd_addr, bus.upd_target);
      end else begin
        logic [2*XW-1:0] e;
        e = exp_q.pop_front();
        check("write_addr",   64'(bus.upd_addr),   64'(e[2*XW-1:XW]));
        check("write_target", 64'(bus.upd_target), 64'(e[XW-1:0]));
      end
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // -------------------------------------------------------------------
  task automatic clear_inputs();
    bus.br0_valid  = 1'b0;
    bus.br0_taken  = 1'b0;
    bus.br0_addr   = '0;
    bus.br0_target = '0;
    bus.br1_valid  = 1'b0;
    bus.br1_taken  = 1'b0;
    bus.br1_addr   = '0;
    bus.br1_target = '0;
    bus.flush_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one cycle of reports; 'accept' is the hand-derived
  // expectation of whether upd_ready is high in that cycle.
  task automatic drive_br(input logic v0, input logic t0,
                          input logic [XW-1:0] a0, input logic [XW-1:0] g0,
                          input logic v1, input logic t1,
                          input logic [XW-1:0] a1, input logic [XW-1:0] g1,
                          input logic accept, input logic flush);
    bus.br0_valid  = v0;
    bus.br0_taken  = t0;
    bus.br0_addr   = a0;
    bus.br0_target = g0;
    bus.br1_valid  = v1;
    bus.br1_taken  = t1;
    bus.br1_addr   = a1;
    bus.br1_target = g1;
    bus.flush_req  = flush;
    if (accept && !flush) begin
      if (v0 && t0 && v1 && t1 && (a0 == a1)) begin
        exp_q.push_back({a1, g1});
      end else begin
        if (v0 && t0) exp_q.push_back({a0, g0});
        if (v1 && t1) exp_q.push_back({a1, g1});
      end
    end
    @(negedge clk);
    rdy_seen = bus.upd_ready;
    wv_seen  = bus.upd_valid;
    idx_seen = bus.inv_index;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic flush_only();
    drive_br(0, 0, '0, '0, 0, 0, '0, '0, 0, 1);
  endtask

  task automatic check_sweep(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      check("sweep_inv_valid", 64'(bus.inv_valid), 64'd1);
      check("sweep_inv_index", 64'(bus.inv_index), 64'(i));
      check("sweep_upd_ready", 64'(bus.upd_ready), 64'd0);
      check("sweep_upd_valid", 64'(bus.upd_valid), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_after_sweep(input string tag);
    @(negedge clk);
    check({tag, "_inv_valid"}, 64'(bus.inv_valid), 64'd0);
    check({tag, "_upd_ready"}, 64'(bus.upd_ready), 64'd1);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_upd_ready"},  64'(bus.upd_ready),  64'd1);
    check({tag, "_upd_valid"},  64'(bus.upd_valid),  64'd0);
    check({tag, "_upd_addr"},   64'(bus.upd_addr),   64'd0);
    check({tag, "_upd_target"}, 64'(bus.upd_target), 64'd0);
    check({tag, "_inv_valid"},  64'(bus.inv_valid),  64'd0);
    check({tag, "_inv_index"},  64'(bus.inv_index),  64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_state"},      64'(dbg_state),      64'(BTB_CTRL_IDLE));
  endtask

  // -------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #12;
    check_all_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single taken br0: write one cycle after acceptance, busy clears next.
    drive_br(1, 1, 32'h100, 32'h200, 0, 0, '0, '0, 1, 0);
    @(negedge clk);
    check("single_upd_valid", 64'(bus.upd_valid), 64'd1);
    check("single_busy",      64'(bus.busy),      64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_upd_valid_after", 64'(bus.upd_valid), 64'd0);
    check("single_busy_after",      64'(bus.busy),      64'd0);
    @(posedge clk);
    #1;

    // Dual taken: br0 then br1 in consecutive cycles.
    drive_br(1, 1, 32'h100, 32'h300, 1, 1, 32'h180, 32'h400, 1, 0);
    @(negedge clk);
    check("dual_first_valid", 64'(bus.upd_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("dual_second_valid", 64'(bus.upd_valid), 64'd1);
    @(posedge clk);
    #1;
    idle(2);

    // Dedup: same PC, only br1's target is written.
    drive_br(1, 1, 32'h100, 32'h500, 1, 1, 32'h100, 32'h600, 1, 0);
    @(negedge clk);
    check("dedup_valid", 64'(bus.upd_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("dedup_single_write", 64'(bus.upd_valid), 64'd0);
    @(posedge clk);
    #1;

    // Fill: ready drops at count 3, stalled reports ignored, then drain.
    drive_br(1, 1, 32'h1000, 32'hA000, 1, 1, 32'h1004, 32'hA004, 1, 0);
    drive_br(1, 1, 32'h1008, 32'hA008, 1, 1, 32'h100C, 32'hA00C, 1, 0);
    check("fill_ready_c2", 64'(rdy_seen), 64'd1);
    drive_br(1, 1, 32'h1010, 32'hA010, 1, 1, 32'h1014, 32'hA014, 0, 0);
    check("fill_ready_low", 64'(rdy_seen), 64'd0);
    @(negedge clk);
    check("fill_ready_back", 64'(bus.upd_ready), 64'd1);
    @(posedge clk);
    #1;
    idle(4);
    @(negedge clk);
    check("fill_drained_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;

    // Flush with three entries queued: nothing more is written.
    drive_br(1, 1, 32'h2000, 32'hB000, 1, 1, 32'h2004, 32'hB004, 1, 0);
    drive_br(1, 1, 32'h2008, 32'hB008, 1, 1, 32'h200C, 32'hB00C, 1, 0);
    flush_only();
    check("flush_no_write", 64'(wv_seen), 64'd0);
    check("flush_pending_discarded", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    check_sweep(0, N - 1);
    check_idle_after_sweep("sweep_end");

    // Flush again at idx 20 restarts the sweep from 0.
    flush_only();
    check_sweep(0, 19);
    flush_only();
    check("restart_seen_idx", 64'(idx_seen), 64'd20);
    check_sweep(0, N - 1);
    check_idle_after_sweep("restart_end");

    // Reset mid-sweep returns to IDLE immediately.
    flush_only();
    check_sweep(0, 9);
    reset_n = 1'b0;
    #1;
    check_all_reset("midsweep_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush wins over same-cycle taken reports.
    drive_br(1, 1, 32'h3000, 32'h3100, 1, 1, 32'h3004, 32'h3104, 0, 1);
    check_sweep(0, N - 1);
    check_idle_after_sweep("flush_wins_end");

    // Not-taken reports produce no writes.
    drive_br(1, 0, 32'h4000, 32'h4100, 1, 0, 32'h4004, 32'h4104, 1, 0);
    @(negedge clk);
    check("not_taken_busy",  64'(bus.busy),      64'd0);
    check("not_taken_valid", 64'(bus.upd_valid), 64'd0);
    @(posedge clk);
    #1;
    idle(2);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
